// File: rtl/ta_cap_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : ta_cap_rx_if
// Brief    : Control, capture-stream and readout signals of ta_cap_rx.
//            The slave side is the receiver; the master side is the host and
//            the sync/merge logic.
// Revision : 1.0 - initial release
// ============================================================================
interface ta_cap_rx_if #(
    parameter int ADC0_1  = 56,
    parameter int CAP0_AW = 8
);
    logic               cap_start;
    logic               cap_abort;
    logic [CAP0_AW:0]   cap_len;
    logic               cap_trig;
    logic               capr_rdy;
    logic [ADC0_1-1:0]  merge_data;
    logic               mereg_datv;
    logic               rd_en;
    logic [ADC0_1-1:0]  rd_data;
    logic               rd_valid;
    logic               cap_busy;
    logic               cap_done;
    logic               cap_err;

    modport master (
        output cap_start, cap_abort, cap_len, capr_rdy, merge_data, mereg_datv, rd_en,
        input  cap_trig, rd_data, rd_valid, cap_busy, cap_done, cap_err
    );

    modport slave (
        input  cap_start, cap_abort, cap_len, capr_rdy, merge_data, mereg_datv, rd_en,
        output cap_trig, rd_data, rd_valid, cap_busy, cap_done, cap_err
    );
endinterface
`default_nettype wire

// File: rtl/ta_cap_rx.sv
`default_nettype none
// ============================================================================
// Module   : ta_cap_rx
// Brief    : Capture receiver. It arms the sync block, stores len merged words
//            into a buffer, then lets the host drain them in order.
//            CAP_TIMESTAMP_EN adds a timestamp header word to the readout.
// Revision : 1.0 - initial release
// ============================================================================
module ta_cap_rx #(
    parameter int ADC0_1   = 56,
    parameter int CAP0_AW  = 8,
    parameter int CAP0_TMO = 65535
) (
    input  wire         clk62,
    input  wire         rst,
    ta_cap_rx_if.slave  bus
);
    localparam int DEPTH = 2**CAP0_AW;
    localparam int TMO_W = $clog2(CAP0_TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CAP0_AW:0]   len_q, len_d;
    logic [CAP0_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CAP0_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               cap_err_q, cap_err_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ADC0_1-1:0]  rd_data_q, rd_data_d;
    logic               wr_en;
    logic               wr_last, rd_last;
    logic               hdr_pend;
    logic [ADC0_1-1:0]  hdr_word;

    logic [ADC0_1-1:0]  mem [DEPTH];

    // Counts are compared one bit wider so a full DEPTH capture ends at the wrap.
    assign wr_last = ({1'b0, wr_ptr_q} + (CAP0_AW+1)'(1)) == len_q;
    assign rd_last = ({1'b0, rd_ptr_q} + (CAP0_AW+1)'(1)) == len_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tmo_d      = tmo_q;
        cap_err_d  = cap_err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;

        if (bus.cap_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cap_start) begin
                        if (bus.cap_len == '0 || bus.cap_len > (CAP0_AW+1)'(DEPTH))
                            len_d = (CAP0_AW+1)'(DEPTH);
                        else
                            len_d = bus.cap_len;
                        cap_err_d = 1'b0;
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        tmo_d     = '0;
                        state_d   = S_ARM;
                    end
                end
                S_ARM: begin
                    tmo_d = tmo_q + 1'b1;
                    // The acknowledge cycle may already carry the first word.
                    if (bus.capr_rdy) begin
                        state_d = S_FILL;
                        if (bus.mereg_datv) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            if (wr_last) state_d = S_DONE;
                        end
                    end else if (tmo_q == TMO_W'(CAP0_TMO - 1)) begin
                        state_d   = S_IDLE;
                        cap_err_d = 1'b1;
                    end
                end
                S_FILL: begin
                    if (bus.mereg_datv) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_last) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rd_en) begin
                        rd_valid_d = 1'b1;
                        if (hdr_pend) begin
                            rd_data_d = hdr_word;
                        end else begin
                            rd_data_d = mem[rd_ptr_q];
                            rd_ptr_d  = rd_ptr_q + 1'b1;
                            if (rd_last) state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk62 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            cap_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tmo_q      <= tmo_d;
            cap_err_q  <= cap_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk62) begin
        if (wr_en) mem[wr_ptr_q] <= bus.merge_data;
    end

`ifdef CAP_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d, ts_snap_q, ts_snap_d;
    logic        hdr_pend_q, hdr_pend_d;
    logic        start_acc, rdy_acc, rd_acc;

    assign start_acc = (state_q == S_IDLE) && bus.cap_start && !bus.cap_abort;
    assign rdy_acc   = (state_q == S_ARM)  && bus.capr_rdy  && !bus.cap_abort;
    assign rd_acc    = (state_q == S_DONE) && bus.rd_en     && !bus.cap_abort;

    always_comb begin
        ts_d       = ts_q + 32'd1;
        ts_snap_d  = rdy_acc ? ts_q : ts_snap_q;
        hdr_pend_d = hdr_pend_q;
        if (start_acc)   hdr_pend_d = 1'b1;
        else if (rd_acc) hdr_pend_d = 1'b0;
    end

    always_ff @(posedge clk62 or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            ts_snap_q  <= '0;
            hdr_pend_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            ts_snap_q  <= ts_snap_d;
            hdr_pend_q <= hdr_pend_d;
        end
    end

    assign hdr_pend = hdr_pend_q;
    assign hdr_word = ADC0_1'({8'hA5, 16'h0000, ts_snap_q});
`else
    assign hdr_pend = 1'b0;
    assign hdr_word = '0;
`endif

    assign bus.cap_trig = (state_q == S_ARM);
    assign bus.cap_busy = (state_q == S_ARM) || (state_q == S_FILL);
    assign bus.cap_done = (state_q == S_DONE);
    assign bus.cap_err  = cap_err_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ta_cap_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ta_cap_rx
// Brief    : Directed self-checking bench for ta_cap_rx (depth 8, timeout 16).
//            Expects a timestamp header word when CAP_TIMESTAMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ta_cap_rx;
    localparam int DW  = 56;
    localparam int AW  = 3;
    localparam int TMO = 16;

    logic clk62 = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [31:0]   ts_exp = '0;
    logic [DW-1:0] expq[$];

    ta_cap_rx_if #(.ADC0_1(DW), .CAP0_AW(AW)) bus ();

    ta_cap_rx #(.ADC0_1(DW), .CAP0_AW(AW), .CAP0_TMO(TMO)) dut (
        .clk62 (clk62),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk62 = ~clk62;

`ifdef CAP_TIMESTAMP_EN
    int unsigned tb_cyc;
    always @(posedge clk62 or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end
`endif

    task automatic tick();
        @(posedge clk62);
        @(negedge clk62);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timestamp the header will carry if capr_rdy is accepted at the coming edge.
    task automatic note_accept();
`ifdef CAP_TIMESTAMP_EN
        ts_exp = tb_cyc;
`endif
    endtask

    task automatic start_cap(input logic [AW:0] len);
        bus.cap_len   = len;
        bus.cap_start = 1'b1;
        tick();
        bus.cap_start = 1'b0;
    endtask

    task automatic feed(input logic v, input logic [DW-1:0] d);
        bus.mereg_datv = v;
        bus.merge_data = d;
        tick();
    endtask

    task automatic rd(input string tag, input logic [DW-1:0] exp);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_rv"}, bus.rd_valid, 1);
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic read_all(input string tag);
`ifdef CAP_TIMESTAMP_EN
        rd({tag, "_hdr"}, {8'hA5, 16'h0000, ts_exp});
`endif
        foreach (expq[i]) begin
            chk($sformatf("%s_done_w%0d", tag, i), bus.cap_done, 1);
            rd($sformatf("%s_w%0d", tag, i), expq[i]);
        end
        chk({tag, "_idle"}, bus.cap_done, 0);
        tick();
        chk({tag, "_rv_low"}, bus.rd_valid, 0);
        chk({tag, "_rd_hold"}, bus.rd_data, expq[expq.size()-1]);
    endtask

    initial begin
        rst            = 1'b1;
        bus.cap_start  = 1'b0;
        bus.cap_abort  = 1'b0;
        bus.cap_len    = '0;
        bus.capr_rdy   = 1'b0;
        bus.merge_data = '0;
        bus.mereg_datv = 1'b0;
        bus.rd_en      = 1'b0;
        tick();
        tick();
        chk("rst_trig", bus.cap_trig, 0);
        chk("rst_busy", bus.cap_busy, 0);
        chk("rst_done", bus.cap_done, 0);
        chk("rst_err",  bus.cap_err,  0);
        chk("rst_rv",   bus.rd_valid, 0);
        chk("rst_rd",   bus.rd_data,  0);
        rst = 1'b0;
        tick();

        // T1: len 4, acknowledge in the 4th ARM cycle, data 1..5 streamed
        start_cap(4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_trig_c%0d", i + 1), bus.cap_trig, 1);
            chk($sformatf("t1_busy_c%0d", i + 1), bus.cap_busy, 1);
            if (i == 1) begin
                bus.cap_start = 1'b1;   // ignored outside IDLE
                bus.cap_len   = 1;
            end
            tick();
            bus.cap_start = 1'b0;
        end
        chk("t1_trig_c4", bus.cap_trig, 1);
        note_accept();
        bus.capr_rdy = 1'b1;
        feed(1, 1);
        bus.capr_rdy = 1'b0;
        chk("t1_trig_drop", bus.cap_trig, 0);
        chk("t1_busy_fill", bus.cap_busy, 1);
        feed(1, 2);
        feed(1, 3);
        chk("t1_done_early", bus.cap_done, 0);
        feed(1, 4);
        chk("t1_done", bus.cap_done, 1);
        chk("t1_busy_done", bus.cap_busy, 0);
        feed(1, 5);
        chk("t1_done_hold", bus.cap_done, 1);
        feed(0, 0);
        expq = '{56'd1, 56'd2, 56'd3, 56'd4};
        read_all("t1");

        // T2: len 3, valid toggling 1,0,1,0,1
        start_cap(3);
        tick();
        note_accept();
        bus.capr_rdy = 1'b1;
        feed(1, 56'hAAAAAAAAAAAAAA);
        bus.capr_rdy = 1'b0;
        feed(0, 56'hBBBBBBBBBBBBBB);
        feed(1, 56'hCCCCCCCCCCCCCC);
        feed(0, 56'hDDDDDDDDDDDDDD);
        chk("t2_done_early", bus.cap_done, 0);
        chk("t2_busy", bus.cap_busy, 1);
        feed(1, 56'hEEEEEEEEEEEEEE);
        chk("t2_done", bus.cap_done, 1);
        feed(0, 0);
        expq = '{56'hAAAAAAAAAAAAAA, 56'hCCCCCCCCCCCCCC, 56'hEEEEEEEEEEEEEE};
        read_all("t2");

        // T3: timeout after 16 ARM cycles, next start clears the error
        start_cap(2);
        begin
            int n;
            n = 0;
            while (bus.cap_trig === 1'b1 && n < 40) begin
                n++;
                tick();
            end
            chk("t3_trig_cycles", 64'(n), 16);
        end
        chk("t3_err", bus.cap_err, 1);
        chk("t3_busy", bus.cap_busy, 0);
        start_cap(4);
        chk("t3_err_clr", bus.cap_err, 0);
        chk("t3_rearm", bus.cap_trig, 1);
        bus.cap_abort = 1'b1;
        tick();
        bus.cap_abort = 1'b0;
        chk("t3_abort_busy", bus.cap_busy, 0);

        // T4: len 0 -> full depth of 8 words, pointer wraps
        start_cap(0);
        note_accept();
        bus.capr_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            feed(1, DW'(56'h100 + i));
            bus.capr_rdy = 1'b0;
            if (i == 6) chk("t4_done_early", bus.cap_done, 0);
        end
        chk("t4_done", bus.cap_done, 1);
        feed(0, 0);
        expq.delete();
        for (int i = 0; i < 8; i++) expq.push_back(DW'(56'h100 + i));
        read_all("t4");
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t4_idle_rd_ignored", bus.rd_valid, 0);

        // T5: abort mid-fill with a simultaneous start, then start+abort in IDLE
        start_cap(6);
        bus.capr_rdy = 1'b1;
        feed(1, 56'h21);
        bus.capr_rdy = 1'b0;
        feed(1, 56'h22);
        bus.cap_abort = 1'b1;
        bus.cap_start = 1'b1;
        feed(1, 56'h23);
        bus.cap_abort = 1'b0;
        bus.cap_start = 1'b0;
        bus.mereg_datv = 1'b0;
        chk("t5_busy", bus.cap_busy, 0);
        chk("t5_trig", bus.cap_trig, 0);
        chk("t5_done", bus.cap_done, 0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t5_no_rv", bus.rd_valid, 0);
        bus.cap_len   = 2;
        bus.cap_start = 1'b1;
        bus.cap_abort = 1'b1;
        tick();
        bus.cap_start = 1'b0;
        bus.cap_abort = 1'b0;
        chk("t5_both_trig", bus.cap_trig, 0);
        chk("t5_both_busy", bus.cap_busy, 0);

        // T6: abort in DONE right after an accepted read
        start_cap(2);
        note_accept();
        bus.capr_rdy = 1'b1;
        feed(1, 56'h31);
        bus.capr_rdy = 1'b0;
        feed(1, 56'h32);
        feed(0, 0);
        chk("t6_done", bus.cap_done, 1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.cap_abort = 1'b1;
        chk("t6_rv", bus.rd_valid, 1);
`ifdef CAP_TIMESTAMP_EN
        chk("t6_rd", bus.rd_data, {8'hA5, 16'h0000, ts_exp});
`else
        chk("t6_rd", bus.rd_data, 56'h31);
`endif
        tick();
        bus.cap_abort = 1'b0;
        chk("t6_abort_done", bus.cap_done, 0);
        chk("t6_abort_rv", bus.rd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
